bpf_cal_ctrl: RTL and testbench

- Multi-channel power-up/calibration sequencer for the band-pass filter bank, the parametrised successor to the single-channel BPF ready model.
- Each channel tracks its power-up enable and calibration request, and raises its ready flag after a programmable number of clock cycles.
- Adds programmable settle time, re-calibration, per-channel done pulses and an aggregate ready flag.
- Sits between the analog-front-end control FSM and the filter channels.

---
 rtl/bpf_pkg.sv | 26 ++
 rtl/bpf_ch_fsm.sv | 101 ++++++++++
 rtl/bpf_cal_ctrl.sv | 70 +++++++
 tb/tb_bpf_cal_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_pkg.sv
// Shared state encoding and calibration-length helper for the BPF calibration sequencer.
package bpf_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_IDLE,
      ST_WAIT,
      ST_CAL,
      ST_READY
   } ch_state_e;

   // A zero length falls back to the default (or to a single cycle) so calibration always ends.
   function automatic logic [31:0] eff_len(input logic [31:0] cyc,
                                           input logic        use_def,
                                           input logic [31:0] def_len);
      logic [31:0] len;
      if (cyc != 32'd0)
         len = cyc;
      else if (use_def)
         len = def_len;
      else
         len = 32'd1;
      return len;
   endfunction

endpackage

// File: rtl/bpf_ch_fsm.sv
// One filter channel: power-up/calibration FSM, calibration counter and CAL edge detector.
// With BPF_SERIAL_CAL_EN defined, requests park in WAIT until the top-level arbiter grants them.
module bpf_ch_fsm
   import bpf_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int CAL_CYC_DEF = 10000
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             pu_i,
   input  logic             cal_i,
   input  logic [CNT_W-1:0] cal_cyc_i,
   input  logic             use_def_i,
   input  logic             grant_i,
   output logic             rdy_o,
   output logic             cal_busy_o,
   output logic             done_o
`ifdef BPF_SERIAL_CAL_EN
   ,
   output logic             in_cal_o,
   output logic             wait_o
`endif
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cal_q;
   logic             done_q, done_d;
   logic [CNT_W-1:0] len;

   assign len = CNT_W'(eff_len(32'(cal_cyc_i), use_def_i, 32'(CAL_CYC_DEF)));

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         cal_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cal_q   <= cal_i;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!pu_i) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: state_d = ST_IDLE;
            // IDLE reacts to the CAL level, READY only to a fresh rising edge.
            ST_IDLE, ST_READY: begin
               if ((state_q == ST_IDLE) ? cal_i : (cal_i && !cal_q)) begin
`ifdef BPF_SERIAL_CAL_EN
                  state_d = ST_WAIT;
`else
                  if (grant_i) begin
                     state_d = ST_CAL;
                     cnt_d   = len;
                  end
`endif
               end
            end
`ifdef BPF_SERIAL_CAL_EN
            ST_WAIT: begin
               if (grant_i) begin
                  state_d = ST_CAL;
                  cnt_d   = len;
               end
            end
`endif
            ST_CAL: begin
               if (cnt_q <= CNT_W'(1))
                  state_d = ST_READY;
               else
                  cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_OFF;
         endcase
      end
      done_d = (state_d == ST_READY) && (state_q != ST_READY);
   end

   // RDY is gated by the live PU so it drops in the same cycle power is removed.
   always_comb begin
      rdy_o      = (state_q == ST_READY) && pu_i;
      cal_busy_o = (state_q == ST_WAIT) || (state_q == ST_CAL);
      done_o     = done_q;
`ifdef BPF_SERIAL_CAL_EN
      in_cal_o   = (state_q == ST_CAL);
      wait_o     = (state_q == ST_WAIT);
`endif
   end

endmodule

// File: rtl/bpf_cal_ctrl.sv
// Multi-channel BPF power-up/calibration sequencer with aggregate ready flag.
// Optional BPF_SERIAL_CAL_EN serialises calibration through a lowest-index-first arbiter.
module bpf_cal_ctrl
   import bpf_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 16,
   parameter int CAL_CYC_DEF = 10000
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [N_CH-1:0]  pu_i,
   input  logic [N_CH-1:0]  cal_i,
   input  logic [CNT_W-1:0] cal_cyc_i,
   input  logic             use_def_i,
   output logic [N_CH-1:0]  rdy_o,
   output logic [N_CH-1:0]  cal_busy_o,
   output logic [N_CH-1:0]  done_o,
   output logic             all_rdy_o
);

   logic [N_CH-1:0] grant;

`ifdef BPF_SERIAL_CAL_EN
   logic [N_CH-1:0] in_cal;
   logic [N_CH-1:0] waiting;

   // Grants are issued only once no channel is in CAL, so each handoff costs one
   // extra cycle: serial channels of length C finish C+1 cycles apart.
   always_comb begin
      grant = '0;
      if (in_cal == '0) begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (waiting[i]) begin
               grant    = '0;
               grant[i] = 1'b1;
            end
         end
      end
   end
`else
   assign grant = '1;
`endif

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      bpf_ch_fsm #(
         .CNT_W      (CNT_W),
         .CAL_CYC_DEF(CAL_CYC_DEF)
      ) u_ch (
         .clk_i     (clk_i),
         .rstn_i    (rstn_i),
         .pu_i      (pu_i[g]),
         .cal_i     (cal_i[g]),
         .cal_cyc_i (cal_cyc_i),
         .use_def_i (use_def_i),
         .grant_i   (grant[g]),
         .rdy_o     (rdy_o[g]),
         .cal_busy_o(cal_busy_o[g]),
         .done_o    (done_o[g])
`ifdef BPF_SERIAL_CAL_EN
         ,
         .in_cal_o  (in_cal[g]),
         .wait_o    (waiting[g])
`endif
      );
   end

   assign all_rdy_o = (|pu_i) && ((rdy_o | ~pu_i) == '1);

endmodule

// File: tb/tb_bpf_cal_ctrl.sv
// Self-checking bench for bpf_cal_ctrl: directed scenarios plus random traffic against a
// timestamp-based reference model (ready time = calibration start edge + effective length).
module tb_bpf_cal_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  pu = '0;
   logic [3:0]  cal = '0;
   logic [15:0] calCyc = '0;
   logic        useDef = 1'b0;
   logic [3:0]  rdy, calBusy, done;
   logic        allRdy;

   int compared = 0;
   int mismatched = 0;

   // Reference model: per channel, whether it is powered and the edge at which it is/was ready.
   int readyAt[4] = '{-1, -1, -1, -1};
   bit powered[4] = '{0, 0, 0, 0};
   bit calPrev[4] = '{0, 0, 0, 0};
   int edgeN = 0;

   always #5 clk = ~clk;

   bpf_cal_ctrl #(.N_CH(4), .CNT_W(16), .CAL_CYC_DEF(10000)) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .pu_i      (pu),
      .cal_i     (cal),
      .cal_cyc_i (calCyc),
      .use_def_i (useDef),
      .rdy_o     (rdy),
      .cal_busy_o(calBusy),
      .done_o    (done),
      .all_rdy_o (allRdy)
   );

   function automatic int effLen(input logic [15:0] cyc, input logic ud);
      return (cyc != 16'd0) ? int'(cyc) : (ud ? 10000 : 1);
   endfunction

   // Advance one clock edge, update the model with the inputs the DUT sampled, settle at negedge.
   task automatic tick();
      @(posedge clk);
      edgeN++;
      for (int i = 0; i < 4; i++) begin
         if (!rstn) begin
            powered[i] = 1'b0;
            readyAt[i] = -1;
            calPrev[i] = 1'b0;
         end else begin
            if (!pu[i]) begin
               powered[i] = 1'b0;
               readyAt[i] = -1;
            end else if (!powered[i]) begin
               powered[i] = 1'b1;
               readyAt[i] = -1;
            end else if (readyAt[i] < 0 && cal[i]) begin
               readyAt[i] = edgeN + effLen(calCyc, useDef);
            end else if (readyAt[i] >= 0 && readyAt[i] < edgeN && cal[i] && !calPrev[i]) begin
               readyAt[i] = edgeN + effLen(calCyc, useDef);
            end
            calPrev[i] = cal[i];
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [12:0] modelOut();
      logic [3:0] r, b, d;
      logic       a;
      r = '0; b = '0; d = '0;
      for (int i = 0; i < 4; i++) begin
         r[i] = pu[i] && powered[i] && readyAt[i] >= 0 && readyAt[i] <= edgeN;
         b[i] = powered[i] && readyAt[i] > edgeN;
         d[i] = powered[i] && readyAt[i] == edgeN;
      end
      a = (pu != 4'h0) && ((r | ~pu) == 4'hF);
      return {r, b, d, a};
   endfunction

   task automatic test_reset();
      rstn = 1'b0; pu = 4'hF; cal = 4'hF; calCyc = 16'd5;
      repeat (3) begin
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== 13'h0) begin
            mismatched++;
            $display("[TB] FAIL reset outputs=%h required=0000", {rdy, calBusy, done, allRdy});
         end
      end
      rstn = 1'b1; pu = 4'h0; cal = 4'h0;
      tick();
   endtask

   task automatic test_basic();
      int rise = -1;
      int doneCnt = 0;
      pu = 4'h1; cal = 4'h0; calCyc = 16'd5; useDef = 1'b0;
      tick();
      cal = 4'h1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== modelOut()) begin
            mismatched++;
            $display("[TB] FAIL basic_model k=%0d got=%h want=%h", k, {rdy, calBusy, done, allRdy}, modelOut());
         end
         if (rdy[0] && rise < 0) rise = k;
         doneCnt += int'(done[0]);
      end
      compared++;
      if (rise !== 5) begin
         mismatched++;
         $display("[TB] FAIL basic_latency got=%0d want=5", rise);
      end
      compared++;
      if (doneCnt !== 1) begin
         mismatched++;
         $display("[TB] FAIL basic_done_pulses got=%0d want=1", doneCnt);
      end
      compared++;
      if (allRdy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL basic_all_rdy got=%b want=1", allRdy);
      end
   endtask

   task automatic test_abort();
      logic sawRdy = 1'b0;
      int   rise = -1;
      cal = 4'h0; pu = 4'h3; calCyc = 16'd10;
      tick();
      cal = 4'h2;
      tick();
      cal = 4'h0;
      tick(); tick();
      pu = 4'h1;
      for (int k = 0; k < 12; k++) begin
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== modelOut()) begin
            mismatched++;
            $display("[TB] FAIL abort_model k=%0d got=%h want=%h", k, {rdy, calBusy, done, allRdy}, modelOut());
         end
         sawRdy |= rdy[1];
      end
      compared++;
      if (sawRdy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_rdy_seen got=%b want=0", sawRdy);
      end
      pu = 4'h3; cal = 4'h2;
      tick();
      tick();
      for (int k = 1; k <= 12; k++) begin
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== modelOut()) begin
            mismatched++;
            $display("[TB] FAIL abort_recal_model k=%0d got=%h want=%h", k, {rdy, calBusy, done, allRdy}, modelOut());
         end
         if (rdy[1] && rise < 0) rise = k;
      end
      compared++;
      if (rise !== 10) begin
         mismatched++;
         $display("[TB] FAIL abort_full_length got=%0d want=10", rise);
      end
      compared++;
      if (allRdy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_all_rdy got=%b want=1", allRdy);
      end
   endtask

   task automatic test_recal_drop();
      int rise = -1;
      pu = 4'h7; cal = 4'h4; calCyc = 16'd3;
      for (int k = 0; k < 8; k++) begin
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== modelOut()) begin
            mismatched++;
            $display("[TB] FAIL recal_model k=%0d got=%h want=%h", k, {rdy, calBusy, done, allRdy}, modelOut());
         end
         if (k == 1) cal = 4'h0;
      end
      cal = 4'h4;
      tick();
      cal = 4'h0;
      compared++;
      if (rdy[2] !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL recal_rdy_drop got=%b want=0", rdy[2]);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== modelOut()) begin
            mismatched++;
            $display("[TB] FAIL recal_wait_model k=%0d got=%h want=%h", k, {rdy, calBusy, done, allRdy}, modelOut());
         end
         if (rdy[2] && rise < 0) rise = k;
      end
      compared++;
      if (rise !== 3) begin
         mismatched++;
         $display("[TB] FAIL recal_latency got=%0d want=3", rise);
      end
      pu = 4'h3;
      #1;
      compared++;
      if (rdy[2] !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL drop_rdy_same_cycle got=%b want=0", rdy[2]);
      end
      tick();
   endtask

   task automatic test_zero_len();
      int rise = -1;
      pu = 4'h8; cal = 4'h0; calCyc = 16'd0; useDef = 1'b0;
      tick(); tick();
      cal = 4'h8;
      tick();
      tick();
      compared++;
      if ({rdy[3], done[3]} !== 2'b11) begin
         mismatched++;
         $display("[TB] FAIL zero_len_one_cycle got=%b want=11", {rdy[3], done[3]});
      end
      useDef = 1'b1; cal = 4'h0;
      tick();
      cal = 4'h8;
      tick();
      cal = 4'h0;
      for (int k = 1; k <= 10003; k++) begin
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== modelOut()) begin
            mismatched++;
            $display("[TB] FAIL zero_len_def_model k=%0d got=%h want=%h", k, {rdy, calBusy, done, allRdy}, modelOut());
         end
         if (rdy[3] && rise < 0) rise = k;
      end
      compared++;
      if (rise !== 10000) begin
         mismatched++;
         $display("[TB] FAIL zero_len_default got=%0d want=10000", rise);
      end
      useDef = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 7) == 0) pu = pu ^ 4'(1 << $urandom_range(0, 3));
         cal    = 4'($urandom_range(0, 15));
         useDef = 1'($urandom_range(0, 1));
         calCyc = 16'($urandom_range(useDef ? 1 : 0, 6));
         tick();
         compared++;
         if ({rdy, calBusy, done, allRdy} !== modelOut()) begin
            mismatched++;
            $display("[TB] FAIL random_model k=%0d got=%h want=%h", k, {rdy, calBusy, done, allRdy}, modelOut());
         end
      end
   endtask

`ifdef BPF_SERIAL_CAL_EN
   task automatic test_serial();
      logic [3:0] expRdy, expBusy;
      pu = 4'hF; cal = 4'h0; calCyc = 16'd4; useDef = 1'b0;
      tick();
      cal = 4'hF;
      tick();
      for (int k = 1; k <= 22; k++) begin
         tick();
         for (int j = 0; j < 4; j++) begin
            expRdy[j]  = (k >= 5 * (j + 1));
            expBusy[j] = !expRdy[j];
         end
         compared++;
         if ({rdy, calBusy} !== {expRdy, expBusy}) begin
            mismatched++;
            $display("[TB] FAIL serial_order k=%0d got=%h want=%h", k, {rdy, calBusy}, {expRdy, expBusy});
         end
      end
   endtask
`endif

   initial begin
      $display("[TB] bpf_cal_ctrl bench start");
      test_reset();
`ifdef BPF_SERIAL_CAL_EN
      test_serial();
`else
      test_basic();
      test_abort();
      test_recal_drop();
      test_zero_len();
      test_random();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
